pixel_transfer: RTL and testbench

//  Frame scanner and pixel feeder directly upstream of imm. On a start pulse it

---
 rtl/pixel_transfer_pkg.sv | 30 +++
 rtl/pixel_transfer_pipe_delay.sv | 41 ++++
 rtl/pixel_transfer.sv | 185 ++++++++++++++++++
 tb/tb_pixel_transfer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_transfer_pkg.sv
// Shared geometry defaults, field widths and types for the pixel_transfer frame scanner.
// Default image dimensions live here so every instance agrees on them.
package pixel_transfer_pkg;

  localparam int DEF_IMG_W    = 320;
  localparam int DEF_IMG_H    = 240;
  localparam int DEF_ADDR_W   = 17;
  localparam int DEF_BROM_LAT = 2;

  localparam int PIX_W = 12;
  localparam int ROW_W = 8;
  localparam int COL_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Tag travelling alongside each BROM read; valid is the MSB.
  typedef struct packed {
    logic             valid;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/pixel_transfer_pipe_delay.sv
// Resettable shift register that carries {valid,row,col} alongside in-flight BROM reads.
// occupied is the OR of all stage valids and tells the scanner when the pipe has drained.
module pixel_transfer_pipe_delay #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             occupied
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;
  logic [DEPTH-1:0][WIDTH-1:0] stage_d;
  logic [DEPTH-1:0]            valid_vec;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign stage_d[gi] = din;
      end else begin : g_link
        assign stage_d[gi] = stage_q[gi-1];
      end
      assign valid_vec[gi] = stage_q[gi][WIDTH-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout     = stage_q[DEPTH-1];
  assign occupied = |valid_vec;

endmodule

// File: rtl/pixel_transfer.sv
// Frame scanner feeding imm: raster-scans the image BROM, realigns returning data with its
// row/col tag, and holds the mask offsets latched at frame start for the whole frame.
module pixel_transfer
  import pixel_transfer_pkg::*;
#(
  parameter int IMG_W    = DEF_IMG_W,
  parameter int IMG_H    = DEF_IMG_H,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int BROM_LAT = DEF_BROM_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pause,
  input  logic [ROW_W-1:0]  mask_row_off_in,
  input  logic [COL_W-1:0]  mask_col_off_in,
  output logic              brom_en,
  output logic [ADDR_W-1:0] brom_addr,
  input  logic [PIX_W-1:0]  brom_data,
  output logic [PIX_W-1:0]  image_pixel,
  output logic [ROW_W-1:0]  pixel_row,
  output logic [COL_W-1:0]  pixel_col,
  output logic              pixel_valid,
  output logic [ROW_W-1:0]  mask_row_offset,
  output logic [COL_W-1:0]  mask_col_offset,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);

  state_e state_q, state_d;

  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              brom_en_q, brom_en_d;
  logic [ADDR_W-1:0] brom_addr_q, brom_addr_d;
  logic [PIX_W-1:0]  pixel_q, pixel_d;
  logic [ROW_W-1:0]  prow_q, prow_d;
  logic [COL_W-1:0]  pcol_q, pcol_d;
  logic              pvalid_q, pvalid_d;
  logic [ROW_W-1:0]  mrow_q, mrow_d;
  logic [COL_W-1:0]  mcol_q, mcol_d;

  logic              frame_start;
  logic              issue;
  logic              issue_last;
  logic [ROW_W-1:0]  issue_row;
  logic [COL_W-1:0]  issue_col;
  logic [ADDR_W-1:0] issue_addr;
  tag_t              tag_in;
  tag_t              tag_out;
  logic              pipe_busy;

  // The start cycle itself issues pixel (0,0), so brom_en rises on the first RUN cycle.
  always_comb begin
    frame_start = (state_q == ST_IDLE) && start;
    issue       = frame_start || ((state_q == ST_RUN) && !pause);
    issue_row   = row_q;
    issue_col   = col_q;
    issue_addr  = addr_q;
    if (state_q == ST_IDLE) begin
      issue_row  = '0;
      issue_col  = '0;
      issue_addr = '0;
    end
    issue_last = (issue_row == LAST_ROW) && (issue_col == LAST_COL);
    tag_in.valid = issue;
    tag_in.row   = issue_row;
    tag_in.col   = issue_col;
  end

  pixel_transfer_pipe_delay #(
    .WIDTH (TAG_W),
    .DEPTH (BROM_LAT)
  ) u_pipe_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (tag_in),
    .dout     (tag_out),
    .occupied (pipe_busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (frame_start) state_d = issue_last ? ST_DRAIN : ST_RUN;
      ST_RUN:   if (issue && issue_last) state_d = ST_DRAIN;
      ST_DRAIN: if (!pipe_busy) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    frame_done = (state_q == ST_DONE);
  end

  // Scan counters step without a multiplier: addr simply tracks row*IMG_W+col.
  always_comb begin
    row_d       = row_q;
    col_d       = col_q;
    addr_d      = addr_q;
    brom_en_d   = issue;
    brom_addr_d = brom_addr_q;
    if (issue) begin
      brom_addr_d = issue_addr;
      addr_d      = issue_addr + 1'b1;
      if (issue_col == LAST_COL) begin
        col_d = '0;
        row_d = issue_row + 1'b1;
      end else begin
        col_d = issue_col + 1'b1;
        row_d = issue_row;
      end
    end

    mrow_d = mrow_q;
    mcol_d = mcol_q;
    if (frame_start) begin
      mrow_d = mask_row_off_in;
      mcol_d = mask_col_off_in;
    end

    pvalid_d = tag_out.valid;
    pixel_d  = pixel_q;
    prow_d   = prow_q;
    pcol_d   = pcol_q;
    if (tag_out.valid) begin
      pixel_d = brom_data;
      prow_d  = tag_out.row;
      pcol_d  = tag_out.col;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q       <= '0;
      col_q       <= '0;
      addr_q      <= '0;
      brom_en_q   <= 1'b0;
      brom_addr_q <= '0;
      pixel_q     <= '0;
      prow_q      <= '0;
      pcol_q      <= '0;
      pvalid_q    <= 1'b0;
      mrow_q      <= '0;
      mcol_q      <= '0;
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      addr_q      <= addr_d;
      brom_en_q   <= brom_en_d;
      brom_addr_q <= brom_addr_d;
      pixel_q     <= pixel_d;
      prow_q      <= prow_d;
      pcol_q      <= pcol_d;
      pvalid_q    <= pvalid_d;
      mrow_q      <= mrow_d;
      mcol_q      <= mcol_d;
    end
  end

  assign brom_en         = brom_en_q;
  assign brom_addr       = brom_addr_q;
  assign image_pixel     = pixel_q;
  assign pixel_row       = prow_q;
  assign pixel_col       = pcol_q;
  assign pixel_valid     = pvalid_q;
  assign mask_row_offset = mrow_q;
  assign mask_col_offset = mcol_q;

endmodule

// File: tb/tb_pixel_transfer.sv
// Self-checking bench for pixel_transfer on an 8x4 image: per-frame scenario table plus
// hand-written reset and mid-frame abort sequences, with a raster-order pixel scoreboard.
module tb_pixel_transfer;
  import pixel_transfer_pkg::*;

  localparam int IMG_W    = 8;
  localparam int IMG_H    = 4;
  localparam int ADDR_W   = 17;
  localparam int BROM_LAT = 2;
  localparam int NPIX     = IMG_W * IMG_H;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              pause;
  logic [ROW_W-1:0]  mask_row_off_in;
  logic [COL_W-1:0]  mask_col_off_in;
  logic              brom_en;
  logic [ADDR_W-1:0] brom_addr;
  logic [PIX_W-1:0]  brom_data;
  logic [PIX_W-1:0]  image_pixel;
  logic [ROW_W-1:0]  pixel_row;
  logic [COL_W-1:0]  pixel_col;
  logic              pixel_valid;
  logic [ROW_W-1:0]  mask_row_offset;
  logic [COL_W-1:0]  mask_col_offset;
  logic              busy;
  logic              frame_done;

  pixel_transfer #(
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H),
    .ADDR_W   (ADDR_W),
    .BROM_LAT (BROM_LAT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .pause           (pause),
    .mask_row_off_in (mask_row_off_in),
    .mask_col_off_in (mask_col_off_in),
    .brom_en         (brom_en),
    .brom_addr       (brom_addr),
    .brom_data       (brom_data),
    .image_pixel     (image_pixel),
    .pixel_row       (pixel_row),
    .pixel_col       (pixel_col),
    .pixel_valid     (pixel_valid),
    .mask_row_offset (mask_row_offset),
    .mask_col_offset (mask_col_offset),
    .busy            (busy),
    .frame_done      (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // BROM returns data=addr one cycle after en; the DUT output register closes the
  // two-cycle read-to-pixel path. Non-read cycles return junk so mistimed captures show.
  always @(posedge clk) begin
    brom_data <= brom_en ? brom_addr[PIX_W-1:0] : 12'hABC;
  end

  typedef struct {
    logic [ROW_W-1:0] row_off;
    logic [COL_W-1:0] col_off;
    logic [COL_W-1:0] col_off_mid;
    int               pause_at;
    int               pause_len;
    bit               restarts;
    int               exp_gaps;
    int               exp_done;
  } vec_t;

  typedef logic [ROW_W+COL_W+PIX_W-1:0] exp_t;

  exp_t sb[$];
  int   n_tests;
  int   n_fail;

  task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [66:0] all_outs();
    return {brom_en, brom_addr, image_pixel, pixel_row, pixel_col, pixel_valid,
            mask_row_offset, mask_col_offset, busy, frame_done};
  endfunction

  // Entered just after a rising edge; start is driven in the loop's cycle 0.
  task automatic run_frame(input int idx, input vec_t v);
    int   n_valid   = 0;
    int   n_gap     = 0;
    int   pend_gap  = 0;
    int   first_cyc = -1;
    int   done_cyc  = -1;
    int   n_done    = 0;
    int   exp_addr  = 0;
    exp_t got;
    sb.delete();
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        sb.push_back({ROW_W'(r), COL_W'(c), PIX_W'(r * IMG_W + c)});
    mask_row_off_in = v.row_off;
    mask_col_off_in = v.col_off;
    for (int cyc = 0; cyc < 120; cyc++) begin
      start = (cyc == 0) || (v.restarts && (cyc == 10 || cyc == 33));
      pause = (cyc >= v.pause_at) && (cyc < v.pause_at + v.pause_len);
      if (cyc == 12) mask_col_off_in = v.col_off_mid;
      @(negedge clk);
      if (brom_en) begin
        check("brom_addr", 67'(brom_addr), 67'(exp_addr));
        exp_addr++;
      end
      if (pixel_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        n_gap    += pend_gap;
        pend_gap = 0;
        n_valid++;
        got = {pixel_row, pixel_col, image_pixel};
        if (sb.size() == 0) begin
          check("extra_valid", 67'(got), 67'(0));
        end else begin
          check("pixel", 67'(got), 67'(sb.pop_front()));
        end
      end else if (first_cyc >= 0) begin
        pend_gap++;
      end
      if (cyc == 20) check("mask_mid_frame", 67'({mask_row_offset, mask_col_offset}),
                           67'({v.row_off, v.col_off}));
      if (frame_done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          check("busy_at_done", 67'(busy), 67'(0));
          check("mask_at_done", 67'({mask_row_offset, mask_col_offset}),
                67'({v.row_off, v.col_off}));
        end
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    pause = 1'b0;
    check("valid_count", 67'(n_valid), 67'(NPIX));
    check("issue_count", 67'(exp_addr), 67'(NPIX));
    check("first_valid_cycle", 67'(first_cyc), 67'(3));
    check("gap_count", 67'(n_gap), 67'(v.exp_gaps));
    check("frame_done_cycle", 67'(done_cyc), 67'(v.exp_done));
    check("frame_done_count", 67'(n_done), 67'(1));
    $display("[TB] frame %0d: valids=%0d gaps=%0d first=%0d done@%0d done_pulses=%0d",
             idx, n_valid, n_gap, first_cyc, done_cyc, n_done);
  endtask

  vec_t vecs[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ab_done;
    int ab_valid;
    n_tests = 0;
    n_fail  = 0;
    vecs[0] = '{row_off: 8'd3,   col_off: 9'd5,   col_off_mid: 9'd200, pause_at: 5,
                pause_len: 3, restarts: 1'b0, exp_gaps: 3, exp_done: 38};
    vecs[1] = '{row_off: 8'd7,   col_off: 9'd200, col_off_mid: 9'd17,  pause_at: 0,
                pause_len: 1, restarts: 1'b1, exp_gaps: 0, exp_done: 35};
    vecs[2] = '{row_off: 8'd0,   col_off: 9'd17,  col_off_mid: 9'd300, pause_at: 32,
                pause_len: 3, restarts: 1'b0, exp_gaps: 0, exp_done: 35};
    vecs[3] = '{row_off: 8'd255, col_off: 9'd511, col_off_mid: 9'd0,   pause_at: 10,
                pause_len: 4, restarts: 1'b1, exp_gaps: 4, exp_done: 39};

    rst_n           = 1'b0;
    start           = 1'b0;
    pause           = 1'b0;
    mask_row_off_in = 8'd9;
    mask_col_off_in = 9'd9;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", all_outs(), 67'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) run_frame(i, vecs[i]);

    // Mid-frame abort: reset lands during the 10th issue.
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("abort_at_issue10", 67'({brom_en, brom_addr}), 67'({1'b1, 17'd9}));
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_async_outputs", all_outs(), 67'(0));
    ab_done  = 0;
    ab_valid = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (frame_done) ab_done++;
      if (pixel_valid) ab_valid++;
      if (cyc == 3) rst_n = 1'b1;
    end
    check("abort_no_frame_done", 67'(ab_done), 67'(0));
    check("abort_no_reissue", 67'(ab_valid), 67'(0));
    $display("[TB] abort: frame_done=%0d valids_after=%0d", ab_done, ab_valid);
    @(posedge clk);
    #1;
    run_frame(4, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
